// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Circular store buffer between the load/store unit and data
//               memory. Slots are allocated in program order at dispatch,
//               filled by the LSU, committed by the ROB and drained in order
//               to memory. Uncommitted slots are discarded on flush.
//               Younger loads forward data from the youngest older store.
// Ports       : clk, rst_n                 - clock / async active-low reset
//               flush                      - discard all uncommitted slots
//               alloc1_req, alloc2_req     - dispatch-lane slot requests
//               sb_addr1, sb_addr2         - slot indices granted per lane
//               sb_tail                    - tail pointer with wrap bit
//               sb_stall                   - fewer than two free slots
//               lsu_st_*                   - executed store write
//               rob_retire{1,2}_sb_*       - in-order store retirement
//               lsu_ld_*                   - load forwarding lookup
//               fwd_hit, fwd_data, fwd_stall - forwarding result
//               mem_wr_*                   - in-order drain to data memory
//               sb_err                     - sticky retire-ordering error
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
   parameter int SB_DEPTH = 32,
   parameter int SB_SIZE  = 5,
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               alloc1_req,
   input  logic               alloc2_req,
   output logic [SB_SIZE-1:0] sb_addr1,
   output logic [SB_SIZE-1:0] sb_addr2,
   output logic [SB_SIZE:0]   sb_tail,
   output logic               sb_stall,
   input  logic               lsu_st_v,
   input  logic [SB_SIZE-1:0] lsu_st_idx,
   input  logic [ADDR_W-1:0]  lsu_st_addr,
   input  logic [DATA_W-1:0]  lsu_st_data,
   input  logic               rob_retire1_sb_v,
   input  logic [SB_SIZE-1:0] rob_retire1_sb_addr,
   input  logic               rob_retire2_sb_v,
   input  logic [SB_SIZE-1:0] rob_retire2_sb_addr,
   input  logic               lsu_ld_v,
   input  logic [ADDR_W-1:0]  lsu_ld_addr,
   input  logic [SB_SIZE:0]   lsu_ld_tail,
   output logic               fwd_hit,
   output logic [DATA_W-1:0]  fwd_data,
   output logic               fwd_stall,
   output logic               mem_wr_v,
   output logic [ADDR_W-1:0]  mem_wr_addr,
   output logic [DATA_W-1:0]  mem_wr_data,
   input  logic               mem_wr_ready,
   output logic               sb_err
);

   localparam int PW = SB_SIZE + 1;

   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_ALLOC  = 2'd1,
      S_READY  = 2'd2,
      S_COMMIT = 2'd3
   } slot_state_t;

   slot_state_t         slot_st   [SB_DEPTH];
   logic [ADDR_W-1:0]   slot_addr [SB_DEPTH];
   logic [DATA_W-1:0]   slot_data [SB_DEPTH];

   logic [PW-1:0]       head, commit, tail;
   logic [PW-1:0]       occupancy, commit_next;
   logic [SB_SIZE-1:0]  head_idx, commit_idx, tail_idx, r2_exp;
   logic                do_alloc, r1_ok, r2_ok, err_set, drain, st_ok;
   logic [SB_DEPTH-1:0] alloc_vec, wr_vec, ret_vec, drain_vec;

   assign head_idx   = head[SB_SIZE-1:0];
   assign commit_idx = commit[SB_SIZE-1:0];
   assign tail_idx   = tail[SB_SIZE-1:0];

   assign occupancy  = tail - head;
   assign sb_stall   = (PW'(SB_DEPTH) - occupancy) < PW'(2);
   assign sb_addr1   = tail_idx;
   assign sb_addr2   = tail_idx + SB_SIZE'(alloc1_req);
   assign sb_tail    = tail;
   assign do_alloc   = !sb_stall && !flush;

   // Retire 2 is only accepted if retire 1 (when present) was accepted, so
   // the committed region always stays contiguous.
   assign r1_ok   = rob_retire1_sb_v && (rob_retire1_sb_addr == commit_idx) &&
                    (slot_st[commit_idx] == S_READY);
   assign r2_exp  = commit_idx + SB_SIZE'(rob_retire1_sb_v);
   assign r2_ok   = rob_retire2_sb_v && (!rob_retire1_sb_v || r1_ok) &&
                    (rob_retire2_sb_addr == r2_exp) &&
                    (slot_st[r2_exp] == S_READY);
   assign err_set = (rob_retire1_sb_v && !r1_ok) || (rob_retire2_sb_v && !r2_ok);
   assign commit_next = commit + PW'(r1_ok) + PW'(r2_ok);

   // Drain looks at the state registered at the start of the cycle, so a slot
   // retired this cycle waits one cycle before reaching memory.
   assign mem_wr_v    = (slot_st[head_idx] == S_COMMIT);
   assign mem_wr_addr = slot_addr[head_idx];
   assign mem_wr_data = slot_data[head_idx];
   assign drain       = mem_wr_v && mem_wr_ready;

   assign st_ok = lsu_st_v && !flush && (slot_st[lsu_st_idx] == S_ALLOC);

   always_comb begin
      alloc_vec = '0;
      wr_vec    = '0;
      ret_vec   = '0;
      drain_vec = '0;
      if (do_alloc && alloc1_req) alloc_vec[tail_idx] = 1'b1;
      if (do_alloc && alloc2_req) alloc_vec[sb_addr2] = 1'b1;
      if (st_ok)                  wr_vec[lsu_st_idx] = 1'b1;
      if (r1_ok)                  ret_vec[rob_retire1_sb_addr] = 1'b1;
      if (r2_ok)                  ret_vec[rob_retire2_sb_addr] = 1'b1;
      if (drain)                  drain_vec[head_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head   <= '0;
         commit <= '0;
         tail   <= '0;
         sb_err <= 1'b0;
      end else begin
         head   <= head + PW'(drain);
         commit <= commit_next;
         if (flush) begin
            tail <= commit_next;
         end else if (do_alloc) begin
            tail <= tail + PW'(alloc1_req) + PW'(alloc2_req);
         end
         sb_err <= sb_err | err_set;
      end
   end

   // A retire beats flush: a store committed in the flush cycle survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SB_DEPTH; i++) begin
            slot_st[i]   <= S_FREE;
            slot_addr[i] <= '0;
            slot_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SB_DEPTH; i++) begin
            if (ret_vec[i]) begin
               slot_st[i] <= S_COMMIT;
            end else if (drain_vec[i]) begin
               slot_st[i] <= S_FREE;
            end else if (flush && (slot_st[i] == S_ALLOC || slot_st[i] == S_READY)) begin
               slot_st[i] <= S_FREE;
            end else if (wr_vec[i]) begin
               slot_st[i]   <= S_READY;
               slot_addr[i] <= lsu_st_addr;
               slot_data[i] <= lsu_st_data;
            end else if (alloc_vec[i]) begin
               slot_st[i] <= S_ALLOC;
            end
         end
      end
   end

   // Scan youngest-older first. A load tail that lies behind head (stale
   // snapshot) yields a distance above the depth and scans nothing.
   always_comb begin
      logic [PW-1:0]      scan_cnt;
      logic [SB_SIZE-1:0] idx;
      logic               found;
      fwd_hit   = 1'b0;
      fwd_stall = 1'b0;
      fwd_data  = '0;
      found     = 1'b0;
      idx       = '0;
      scan_cnt  = lsu_ld_tail - head;
      if (lsu_ld_v && (scan_cnt <= PW'(SB_DEPTH))) begin
         for (int i = 0; i < SB_DEPTH; i++) begin
            idx = lsu_ld_tail[SB_SIZE-1:0] - SB_SIZE'(i) - SB_SIZE'(1);
            if (!found && (PW'(i) < scan_cnt)) begin
               if (slot_st[idx] == S_ALLOC) begin
                  fwd_stall = 1'b1;
                  found     = 1'b1;
               end else if ((slot_st[idx] == S_READY || slot_st[idx] == S_COMMIT) &&
                            (slot_addr[idx] == lsu_ld_addr)) begin
                  fwd_hit  = 1'b1;
                  fwd_data = slot_data[idx];
                  found    = 1'b1;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer. A sequence-number based
//               model of the buffer is checked against the DUT every cycle;
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

   localparam int DEPTH = 32;
   localparam int SZ    = 5;
   localparam int AW    = 16;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush, alloc1_req, alloc2_req;
   logic [SZ-1:0] sb_addr1, sb_addr2;
   logic [SZ:0]   sb_tail;
   logic          sb_stall;
   logic          lsu_st_v;
   logic [SZ-1:0] lsu_st_idx;
   logic [AW-1:0] lsu_st_addr;
   logic [DW-1:0] lsu_st_data;
   logic          r1_v, r2_v;
   logic [SZ-1:0] r1_addr, r2_addr;
   logic          lsu_ld_v;
   logic [AW-1:0] lsu_ld_addr;
   logic [SZ:0]   lsu_ld_tail;
   logic          fwd_hit, fwd_stall;
   logic [DW-1:0] fwd_data;
   logic          mem_wr_v, mem_wr_ready;
   logic [AW-1:0] mem_wr_addr;
   logic [DW-1:0] mem_wr_data;
   logic          sb_err;

   store_buffer #(.SB_DEPTH(DEPTH), .SB_SIZE(SZ), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .alloc1_req(alloc1_req), .alloc2_req(alloc2_req),
      .sb_addr1(sb_addr1), .sb_addr2(sb_addr2), .sb_tail(sb_tail), .sb_stall(sb_stall),
      .lsu_st_v(lsu_st_v), .lsu_st_idx(lsu_st_idx), .lsu_st_addr(lsu_st_addr),
      .lsu_st_data(lsu_st_data),
      .rob_retire1_sb_v(r1_v), .rob_retire1_sb_addr(r1_addr),
      .rob_retire2_sb_v(r2_v), .rob_retire2_sb_addr(r2_addr),
      .lsu_ld_v(lsu_ld_v), .lsu_ld_addr(lsu_ld_addr), .lsu_ld_tail(lsu_ld_tail),
      .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
      .mem_wr_v(mem_wr_v), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_ready(mem_wr_ready), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: stores numbered by absolute sequence -------------
   // Entries [m_head, m_commit) are committed, [m_commit, m_tail) speculative.
   bit            m_wr   [DEPTH];
   logic [AW-1:0] m_addr [DEPTH];
   logic [DW-1:0] m_data [DEPTH];
   int            m_head, m_commit, m_tail;
   bit            m_err;

   function automatic bit m_stall();
      return (DEPTH - (m_tail - m_head)) < 2;
   endfunction

   always @(posedge clk or negedge rst_n) begin : p_model
      int  c, t, e2;
      bit  ok1, ok2, stl;
      if (!rst_n) begin
         m_head = 0; m_commit = 0; m_tail = 0; m_err = 0;
         for (int i = 0; i < DEPTH; i++) begin
            m_wr[i] = 0; m_addr[i] = '0; m_data[i] = '0;
         end
      end else begin
         c   = m_commit;
         t   = m_tail;
         stl = m_stall();
         ok1 = r1_v && (int'(r1_addr) == c % DEPTH) && (c < t) && m_wr[c % DEPTH];
         e2  = c + (r1_v ? 1 : 0);
         ok2 = r2_v && (!r1_v || ok1) && (int'(r2_addr) == e2 % DEPTH) &&
               (e2 < t) && m_wr[e2 % DEPTH];
         if ((r1_v && !ok1) || (r2_v && !ok2)) m_err = 1;
         m_commit = c + int'(ok1) + int'(ok2);
         if (m_head < c && mem_wr_ready) m_head++;
         if (lsu_st_v && !flush) begin
            for (int n = c; n < t; n++) begin
               if (n % DEPTH == int'(lsu_st_idx) && !m_wr[n % DEPTH]) begin
                  m_wr[n % DEPTH]   = 1;
                  m_addr[n % DEPTH] = lsu_st_addr;
                  m_data[n % DEPTH] = lsu_st_data;
               end
            end
         end
         if (flush) begin
            m_tail = m_commit;
         end else if (!stl) begin
            if (alloc1_req) begin m_wr[m_tail % DEPTH] = 0; m_tail++; end
            if (alloc2_req) begin m_wr[m_tail % DEPTH] = 0; m_tail++; end
         end
      end
   end

   task automatic m_fwd(output bit hit, output bit stl, output logic [DW-1:0] data);
      int cnt, n;
      hit = 0; stl = 0; data = '0;
      cnt = (int'(lsu_ld_tail) - (m_head % (2*DEPTH)) + 2*DEPTH) % (2*DEPTH);
      if (lsu_ld_v && cnt <= DEPTH) begin
         for (int j = cnt - 1; j >= 0; j--) begin
            n = m_head + j;
            if (n < m_tail && !hit && !stl) begin
               if (!m_wr[n % DEPTH]) stl = 1;
               else if (m_addr[n % DEPTH] == lsu_ld_addr) begin
                  hit = 1; data = m_data[n % DEPTH];
               end
            end
         end
      end
   endtask

   always @(negedge clk) begin : p_cmp
      bit eh, es;
      logic [DW-1:0] ed;
      if (rst_n === 1'b1) begin
         chk("sb_addr1",  32'(sb_addr1), m_tail % DEPTH);
         chk("sb_addr2",  32'(sb_addr2), (m_tail + int'(alloc1_req)) % DEPTH);
         chk("sb_tail",   32'(sb_tail),  m_tail % (2*DEPTH));
         chk("sb_stall",  32'(sb_stall), 32'(m_stall()));
         chk("mem_wr_v",  32'(mem_wr_v), 32'(m_head < m_commit));
         if (m_head < m_commit) begin
            chk("mem_wr_addr", 32'(mem_wr_addr), 32'(m_addr[m_head % DEPTH]));
            chk("mem_wr_data", 32'(mem_wr_data), 32'(m_data[m_head % DEPTH]));
         end
         m_fwd(eh, es, ed);
         chk("fwd_hit",   32'(fwd_hit),   32'(eh));
         chk("fwd_stall", 32'(fwd_stall), 32'(es));
         chk("fwd_data",  32'(fwd_data),  32'(ed));
         chk("sb_err",    32'(sb_err),    32'(m_err));
      end
   end

   // ---------------- memory write log ----------------
   bit            log_en = 0;
   logic [AW-1:0] log_addr [$];
   logic [DW-1:0] log_data [$];
   always @(posedge clk) begin
      if (log_en && rst_n && mem_wr_v && mem_wr_ready) begin
         log_addr.push_back(mem_wr_addr);
         log_data.push_back(mem_wr_data);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      flush = 0; alloc1_req = 0; alloc2_req = 0;
      lsu_st_v = 0; lsu_st_idx = '0; lsu_st_addr = '0; lsu_st_data = '0;
      r1_v = 0; r1_addr = '0; r2_v = 0; r2_addr = '0;
      lsu_ld_v = 0; lsu_ld_addr = '0; lsu_ld_tail = '0;
      mem_wr_ready = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic st_write(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
      lsu_st_v = 1; lsu_st_idx = SZ'(idx); lsu_st_addr = a; lsu_st_data = d;
      tick();
      lsu_st_v = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      do_reset();
      #1;
      // reset state
      chk("rst_tail",  32'(sb_tail),  0);
      chk("rst_stall", 32'(sb_stall), 0);
      chk("rst_memv",  32'(mem_wr_v), 0);
      chk("rst_err",   32'(sb_err),   0);
      chk("rst_addr2", 32'(sb_addr2), 0);

      // T1: fill two per cycle
      for (int c = 0; c < 15; c++) begin
         alloc1_req = 1; alloc2_req = 1;
         #1;
         chk("t1_addr1", 32'(sb_addr1), 2*c);
         chk("t1_addr2", 32'(sb_addr2), 2*c + 1);
         chk("t1_stall", 32'(sb_stall), 0);
         tick();
      end
      idle();
      #1;
      chk("t1_tail30", 32'(sb_tail), 30);
      alloc1_req = 1;
      tick();
      #1;
      chk("t1_stall31", 32'(sb_stall), 1);
      chk("t1_tail31",  32'(sb_tail), 31);
      alloc1_req = 1; alloc2_req = 1;
      tick();
      tick();
      idle();
      #1;
      chk("t1_ignored", 32'(sb_tail), 31);

      // T2: in-order flow
      do_reset();
      alloc1_req = 1;
      tick();
      idle();
      st_write(0, 16'h0040, 16'hBEEF);
      r1_v = 1; r1_addr = 0; mem_wr_ready = 1;
      tick();
      r1_v = 0;
      #1;
      chk("t2_memv",    32'(mem_wr_v), 1);
      chk("t2_memaddr", 32'(mem_wr_addr), 32'h0040);
      chk("t2_memdata", 32'(mem_wr_data), 32'hBEEF);
      tick();
      #1;
      chk("t2_drained", 32'(mem_wr_v), 0);
      idle();

      // T3: flush
      do_reset();
      alloc1_req = 1; alloc2_req = 1;
      tick();
      tick();
      idle();
      for (int i = 0; i < 4; i++) st_write(i, AW'(16'h0100 + i), DW'(16'h00A0 + i));
      r1_v = 1; r1_addr = 0; r2_v = 1; r2_addr = 1;
      tick();
      idle();
      flush = 1;
      tick();
      flush = 0;
      #1;
      chk("t3_tail",  32'(sb_tail),  2);
      chk("t3_addr1", 32'(sb_addr1), 2);
      chk("t3_memv",  32'(mem_wr_v), 1);
      chk("t3_mem0",  32'(mem_wr_addr), 32'h0100);
      mem_wr_ready = 1;
      tick();
      #1;
      chk("t3_mem1",  32'(mem_wr_addr), 32'h0101);
      tick();
      mem_wr_ready = 0;
      #1;
      chk("t3_empty", 32'(mem_wr_v), 0);
      lsu_ld_v = 1; lsu_ld_addr = 16'h0102; lsu_ld_tail = 6'd4;
      #1;
      chk("t3_nohit",   32'(fwd_hit),   0);
      chk("t3_nostall", 32'(fwd_stall), 0);
      idle();
      alloc1_req = 1;
      tick();
      idle();
      #1;
      chk("t3_realloc", 32'(sb_tail), 3);

      // T4: forwarding
      do_reset();
      alloc1_req = 1; alloc2_req = 1;
      tick();
      idle();
      st_write(0, 16'h0010, 16'h1111);
      st_write(1, 16'h0010, 16'h2222);
      lsu_ld_v = 1; lsu_ld_addr = 16'h0010; lsu_ld_tail = 6'd2;
      #1;
      chk("t4_hit",   32'(fwd_hit),   1);
      chk("t4_data",  32'(fwd_data),  32'h2222);
      chk("t4_stall", 32'(fwd_stall), 0);
      lsu_ld_tail = 6'd1;
      #1;
      chk("t4_older", 32'(fwd_data), 32'h1111);
      lsu_ld_addr = 16'h0020; lsu_ld_tail = 6'd2;
      #1;
      chk("t4_miss",  32'(fwd_hit), 0);
      tick();
      idle();
      do_reset();
      alloc1_req = 1; alloc2_req = 1;
      tick();
      idle();
      st_write(0, 16'h0010, 16'h1111);
      lsu_ld_v = 1; lsu_ld_addr = 16'h0010; lsu_ld_tail = 6'd2;
      #1;
      chk("t4_unk_stall", 32'(fwd_stall), 1);
      chk("t4_unk_hit",   32'(fwd_hit),   0);
      lsu_ld_v = 0;
      #1;
      chk("t4_off_stall", 32'(fwd_stall), 0);
      chk("t4_off_data",  32'(fwd_data),  0);
      idle();

      // T5: 40 stores end to end with wrap-around
      do_reset();
      log_en = 1;
      for (int k = 0; k < 42; k++) begin
         alloc1_req   = (k < 40);
         lsu_st_v     = (k >= 1 && k <= 40);
         lsu_st_idx   = SZ'((k - 1) % DEPTH);
         lsu_st_addr  = AW'(16'h2000 + k - 1);
         lsu_st_data  = DW'(16'h5A00 ^ ((k - 1) * 37));
         r1_v         = (k >= 2);
         r1_addr      = SZ'((k - 2) % DEPTH);
         mem_wr_ready = (k % 2 == 1);
         if (k == 31) begin #1; chk("t5_wrap0", 32'(sb_tail), 31); end
         if (k == 32) begin #1; chk("t5_wrap1", 32'(sb_tail[SZ]), 1); end
         tick();
      end
      idle();
      for (int k = 0; k < 80; k++) begin
         mem_wr_ready = (k % 2 == 0);
         tick();
      end
      idle();
      log_en = 0;
      chk("t5_count", log_addr.size(), 40);
      for (int k = 0; k < 40 && k < log_addr.size(); k++) begin
         chk("t5_addr", 32'(log_addr[k]), 32'(AW'(16'h2000 + k)));
         chk("t5_data", 32'(log_data[k]), 32'(DW'(16'h5A00 ^ (k * 37))));
      end

      // T6: ordering error and asynchronous reset
      do_reset();
      alloc1_req = 1; alloc2_req = 1;
      tick();
      tick();
      idle();
      for (int i = 0; i < 4; i++) st_write(i, AW'(16'h0300 + i), DW'(16'h0C00 + i));
      r1_v = 1; r1_addr = 0; r2_v = 1; r2_addr = 1;
      tick();
      idle();
      #1;
      chk("t6_noerr", 32'(sb_err), 0);
      r1_v = 1; r1_addr = 3;
      tick();
      idle();
      #1;
      chk("t6_err", 32'(sb_err), 1);
      r1_v = 1; r1_addr = 2; r2_v = 1; r2_addr = 3;
      tick();
      idle();
      mem_wr_ready = 1;
      #1;
      chk("t6_draining", 32'(mem_wr_v), 1);
      rst_n = 0;
      #1;
      chk("t6_async_memv", 32'(mem_wr_v), 0);
      chk("t6_async_err",  32'(sb_err),   0);
      idle();
      @(posedge clk);
      #1;
      rst_n = 1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
